// File: rtl/rgst_file_pkg.sv
// Shared definitions for the byte register file and its read-side sequencer.
package rgst_file_pkg;

   localparam int unsigned DataWDefault = 8;
   localparam int unsigned AddrWDefault = 2;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      SEND,
      DONE
   } rd_state_t;

endpackage

// File: rtl/rgst_file_reader.sv
// Read-side sequencer: walks the register file read port from a start address,
// streams each byte on a valid/ready interface, and accumulates a modular checksum.
module rgst_file_reader
   import rgst_file_pkg::*;
#(
   parameter int unsigned DATA_W = DataWDefault,
   parameter int unsigned ADDR_W = AddrWDefault
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [ADDR_W:0]   count,
   output logic              busy,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic              done,
   output logic [DATA_W-1:0] checksum
);

   rd_state_t         state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W:0]   remaining_q, remaining_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              out_valid_q, out_valid_d;
   logic              out_last_q, out_last_d;
   logic              done_q, done_d;
   logic [DATA_W-1:0] checksum_q, checksum_d;

   // Next-state logic for the FSM, address/remaining counters and checksum.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      remaining_d = remaining_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      done_d      = done_q;
      checksum_d  = checksum_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               checksum_d = '0;
               if (count != '0) begin
                  addr_d      = start_addr;
                  remaining_d = count;
                  state_d     = FETCH;
               end else begin
                  done_d  = 1'b1;
                  state_d = DONE;
               end
            end
         end
         FETCH: begin
            // rd_addr has been stable since the previous edge, so rd_data is valid now.
            out_data_d  = rd_data;
            checksum_d  = checksum_q + rd_data;
            out_last_d  = (remaining_q == (ADDR_W + 1)'(1));
            out_valid_d = 1'b1;
            state_d     = SEND;
         end
         SEND: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               out_last_d  = 1'b0;
               remaining_d = remaining_q - (ADDR_W + 1)'(1);
               if (out_last_q) begin
                  done_d  = 1'b1;
                  state_d = DONE;
               end else begin
                  // Address only moves on the edge that enters FETCH; wraps naturally.
                  addr_d  = addr_q + ADDR_W'(1);
                  state_d = FETCH;
               end
            end
         end
         DONE: begin
            done_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State registers with synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         remaining_q <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         done_q      <= 1'b0;
         checksum_q  <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         remaining_q <= remaining_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         done_q      <= done_d;
         checksum_q  <= checksum_d;
      end
   end

   assign busy      = (state_q != IDLE);
   assign rd_addr   = addr_q;
   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign done      = done_q;
   assign checksum  = checksum_q;

endmodule

// File: tb/tb_rgst_file_reader.sv
// Bench for rgst_file_reader: a 4-entry byte file modelled as an array feeds the
// read port; each transfer is compared against a byte list and running sums.
module tb_rgst_file_reader;

   localparam int unsigned DW    = 8;
   localparam int unsigned AW    = 2;
   localparam int unsigned DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [AW-1:0] start_addr;
   logic [AW:0]   count;
   logic          busy;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready;
   logic          out_last;
   logic          done;
   logic [DW-1:0] checksum;

   logic [DW-1:0] mem [DEPTH];
   logic          corrupt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // Register file read port; corrupt emulates a concurrent write during a stall.
   assign rd_data = corrupt ? ~mem[rd_addr] : mem[rd_addr];

   rgst_file_reader #(
      .DATA_W (DW),
      .ADDR_W (AW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .start_addr (start_addr),
      .count      (count),
      .busy       (busy),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_last   (out_last),
      .done       (done),
      .checksum   (checksum)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv)
      else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_values();
      check("rst_busy", busy, 0);
      check("rst_rd_addr", rd_addr, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_last", out_last, 0);
      check("rst_done", done, 0);
      check("rst_checksum", checksum, 0);
   endtask

   // One complete transfer checked beat by beat against the expected byte list.
   task automatic run_xfer(input int sa, input int cnt, input int ready_pct, input int stall,
                           input bit junk, input bit corrupt_en);
      logic [DW-1:0] exp_q [$];
      logic [DW-1:0] total;
      logic [DW-1:0] prefix;
      logic [DW-1:0] held;
      int idx;
      int cyc;
      int stall_left;
      bit seen_done;
      bit stalled;
      bit timed;
      total = '0;
      held = '0;
      idx = 0;
      stall_left = stall;
      seen_done = 1'b0;
      stalled = 1'b0;
      timed = (ready_pct == 100) && (stall == 0);
      for (int i = 0; i < cnt; i++) begin
         exp_q.push_back(mem[(sa + i) % DEPTH]);
         total += mem[(sa + i) % DEPTH];
      end

      start = 1'b1;
      start_addr = AW'(sa);
      count = (AW + 1)'(cnt);
      tick();
      start = 1'b0;
      cyc = 1;

      while (!seen_done && cyc < 200) begin
         check("busy", busy, 1);
         if (done) begin
            seen_done = 1'b1;
            check("done_beats", idx, cnt);
            check("done_checksum", checksum, total);
            check("done_no_valid", out_valid, 0);
            if (timed) check("done_cycle", cyc, 2 * cnt + 1);
            // A start in the done cycle must be ignored.
            start = 1'b1;
            start_addr = AW'($urandom);
            count = 3'd3;
            corrupt = 1'b0;
         end else begin
            if (stalled) begin
               check("stall_valid", out_valid, 1);
               if (out_valid) check("stall_data", out_data, held);
            end
            if (out_valid) begin
               if (idx < cnt) begin
                  prefix = '0;
                  for (int i = 0; i <= idx; i++) prefix += exp_q[i];
                  check("beat_data", out_data, exp_q[idx]);
                  check("beat_last", out_last, (idx == cnt - 1));
                  check("beat_checksum", checksum, prefix);
                  if (timed) check("beat_cycle", cyc, 2 * idx + 2);
               end else begin
                  check("extra_beat", out_valid, 0);
               end
            end
            out_ready = ($urandom_range(99) < ready_pct);
            if (out_valid && stall_left > 0) begin
               out_ready = 1'b0;
               stall_left--;
            end
            stalled = out_valid && !out_ready;
            held = out_data;
            corrupt = corrupt_en && stalled;
            if (out_valid && out_ready) idx++;
            if (junk) begin
               start = 1'($urandom_range(1));
               start_addr = AW'($urandom);
               count = (AW + 1)'($urandom);
            end
         end
         tick();
         cyc++;
      end

      start = 1'b0;
      corrupt = 1'b0;
      if (!seen_done) begin
         check("done_timeout", seen_done, 1);
      end else begin
         check("idle_busy", busy, 0);
         check("idle_no_done", done, 0);
         check("idle_no_valid", out_valid, 0);
         check("idle_checksum_hold", checksum, total);
      end
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      start_addr = '0;
      count = '0;
      out_ready = 1'b0;
      corrupt = 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
      tick();
      tick();
      check_reset_values();
      rst = 1'b0;
      tick();

      // Full dump, wrap, backpressure, empty transfer, ignored starts while busy.
      mem[0] = 8'h11;
      mem[1] = 8'h22;
      mem[2] = 8'h33;
      mem[3] = 8'h44;
      run_xfer(0, 4, 100, 0, 1'b0, 1'b0);
      run_xfer(3, 3, 100, 0, 1'b0, 1'b0);
      run_xfer(0, 2, 100, 5, 1'b0, 1'b1);
      run_xfer(0, 0, 100, 0, 1'b0, 1'b0);
      run_xfer(1, 4, 100, 0, 1'b1, 1'b0);

      // Checksum overflow and over-depth wrap.
      mem[0] = 8'hFF;
      mem[1] = 8'h02;
      mem[2] = 8'h00;
      mem[3] = 8'h00;
      run_xfer(0, 5, 100, 0, 1'b0, 1'b0);

      // Reset during the second SEND drops the transfer without a done pulse.
      start = 1'b1;
      start_addr = '0;
      count = 3'd5;
      out_ready = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      check("mid_valid", out_valid, 1);
      check("mid_data", out_data, mem[1]);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_reset_values();
      tick();
      check("post_rst_done", done, 0);
      check("post_rst_busy", busy, 0);
      run_xfer(2, 7, 100, 0, 1'b0, 1'b0);

      // Randomized transfers with random backpressure, stray starts and write disturbance.
      for (int n = 0; n < 25; n++) begin
         for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
         run_xfer($urandom_range(0, DEPTH - 1), $urandom_range(0, 7), $urandom_range(30, 100),
                  $urandom_range(0, 3), 1'($urandom_range(1)), 1'b1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
